// File: rtl/plotter_pkg.sv
// Shared types and constants for the frame transmit controller: FSM state
// encoding, default frame marker bytes and the buffer address width helper.
package plotter_pkg;

    // Controller states; IDLE is the only state in which busy is low.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_SEND = 3'd4,
        ST_EOF  = 3'd5,
        ST_ACK  = 3'd6
    } state_t;

    // Default start/end-of-frame marker bytes.
    localparam logic [7:0] SOF_DEFAULT = 8'hAA;
    localparam logic [7:0] EOF_DEFAULT = 8'h55;

    // Address width needed to index every pixel of a w x h buffer.
    // A one-pixel image still gets a one-bit address.
    function automatic int addr_width(input int w, input int h);
        int n;
        n = w * h;
        if (n < 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/frame_tx_ctrl_if.sv
// Buffer-read and byte-stream signals between the frame transmit controller
// (master side) and the frame buffer / UART transmitter (slave side).
interface frame_tx_ctrl_if
    import plotter_pkg::*;
#(
    parameter int IMG_W = 176,
    parameter int IMG_H = 240
);
    localparam int AW = addr_width(IMG_W, IMG_H);

    // Frame buffer read port: data arrives one cycle after rd_en.
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    // Byte stream to the transmitter: transfer on tx_valid && tx_ready.
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );

endinterface

// File: rtl/frame_tx_ctrl.sv
// Frame transmit controller: when a completed frame sits in the buffer it
// sends SOF, every pixel in address order, then EOF to the UART, and pulses
// frame_ack once the last byte has been accepted.
//
// All outputs are registered. They are computed from the next state, so each
// output register always matches a decode of the state register; this keeps
// tx_valid high in the first cycle of SOF/SEND/EOF, so a tx_ready already
// present in that cycle completes the transfer immediately.
module frame_tx_ctrl
    import plotter_pkg::*;
#(
    parameter int         IMG_W    = 176,
    parameter int         IMG_H    = 240,
    parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
    parameter logic [7:0] EOF_BYTE = EOF_DEFAULT
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_ready,
    frame_tx_ctrl_if.master  bus,
    output logic             frame_ack,
    output logic             busy
);

    localparam int            NPIX     = IMG_W * IMG_H;
    localparam int            AW       = addr_width(IMG_W, IMG_H);
    localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] count_r;
    logic [AW-1:0] count_nxt_s;
    logic [7:0]    tx_data_r;
    logic [7:0]    tx_data_nxt_s;
    logic          rd_en_r;
    logic [AW-1:0] rd_addr_r;
    logic          tx_valid_r;
    logic          frame_ack_r;
    logic          busy_r;
    logic          xfer_s;

    assign xfer_s = tx_valid_r & bus.tx_ready;

    // Next state, pixel counter and byte-to-offer; every path assigns all three.
    always_comb begin
        state_nxt_s   = state_r;
        count_nxt_s   = count_r;
        tx_data_nxt_s = tx_data_r;

        case (state_r)
            ST_IDLE: begin
                if (frame_ready) begin
                    state_nxt_s = ST_SOF;
                    count_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SOF: begin
                if (xfer_s) begin
                    state_nxt_s = ST_RD;
                end else begin
                    state_nxt_s = ST_SOF;
                end
            end
            ST_RD: begin
                state_nxt_s = ST_CAP;
            end
            ST_CAP: begin
                state_nxt_s = ST_SEND;
            end
            ST_SEND: begin
                if (xfer_s) begin
                    // Counter stops at the last pixel; it never wraps.
                    if (count_r == LAST_PIX) begin
                        state_nxt_s = ST_EOF;
                    end else begin
                        state_nxt_s = ST_RD;
                        count_nxt_s = count_r + AW'(1);
                    end
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_EOF: begin
                if (xfer_s) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_EOF;
                end
            end
            ST_ACK: begin
                // Always pass through IDLE, even if frame_ready is still high.
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = '0;
            end
        endcase

        // Byte offered: markers on entry to SOF/EOF, buffer data captured in
        // CAP, otherwise held so it stays stable while stalled.
        if (state_nxt_s == ST_SOF) begin
            tx_data_nxt_s = SOF_BYTE;
        end else if (state_nxt_s == ST_EOF) begin
            tx_data_nxt_s = EOF_BYTE;
        end else if (state_r == ST_CAP) begin
            tx_data_nxt_s = bus.rd_data;
        end else begin
            tx_data_nxt_s = tx_data_r;
        end
    end

    // State and pixel counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            count_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Output registers, decoded from the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_en_r     <= 1'b0;
            rd_addr_r   <= '0;
            tx_valid_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            frame_ack_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rd_en_r     <= (state_nxt_s == ST_RD);
            rd_addr_r   <= (state_nxt_s == ST_RD) ? count_nxt_s : '0;
            tx_valid_r  <= (state_nxt_s == ST_SOF) || (state_nxt_s == ST_SEND) ||
                           (state_nxt_s == ST_EOF);
            tx_data_r   <= tx_data_nxt_s;
            frame_ack_r <= (state_nxt_s == ST_ACK);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.rd_en    = rd_en_r;
    assign bus.rd_addr  = rd_addr_r;
    assign bus.tx_valid = tx_valid_r;
    assign bus.tx_data  = tx_data_r;
    assign frame_ack    = frame_ack_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_frame_tx_ctrl.sv
// Directed testbench for frame_tx_ctrl: a 4x2 instance exercises the stream,
// back-pressure, frame_ready and reset behaviour; a 5x3 instance covers a
// non-power-of-two pixel count at the counter boundary.
module tb_frame_tx_ctrl;
    import plotter_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic fr_a, fr_b;
    logic ack_a, busy_a, ack_b, busy_b;

    always #5 clk = ~clk;

    frame_tx_ctrl_if #(.IMG_W(4), .IMG_H(2)) bus_a ();
    frame_tx_ctrl_if #(.IMG_W(5), .IMG_H(3)) bus_b ();

    frame_tx_ctrl #(.IMG_W(4), .IMG_H(2), .SOF_BYTE(8'hAA), .EOF_BYTE(8'h55)) dut_a (
        .clk(clk), .reset_n(reset_n), .frame_ready(fr_a), .bus(bus_a),
        .frame_ack(ack_a), .busy(busy_a)
    );

    frame_tx_ctrl #(.IMG_W(5), .IMG_H(3), .SOF_BYTE(8'hAA), .EOF_BYTE(8'h55)) dut_b (
        .clk(clk), .reset_n(reset_n), .frame_ready(fr_b), .bus(bus_b),
        .frame_ack(ack_b), .busy(busy_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ready_mode = 0;
    int rdy_cnt = 0;

    // Monitor state for instance A.
    logic [7:0] bytes_q[$];
    int         tcyc_q[$];
    int reads, max_addr, first_addr, addr_viol, acks, idle_gap, stall_viol;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    // Monitor state for instance B.
    int b_xfers = 0, b_reads = 0, b_max = 0, b_acks = 0, b_last = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clr();
        bytes_q.delete();
        tcyc_q.delete();
        reads = 0; max_addr = 0; first_addr = -1; addr_viol = 0;
        acks = 0; idle_gap = 0; stall_viol = 0;
    endtask

    // Expected 4x2 stream with mem[i] = i+1: AA, 01..08, 55.
    task automatic check_stream(input string tag, input int off);
        int exp_b, got_b;
        for (int k = 0; k < 10; k++) begin
            exp_b = (k == 0) ? 32'hAA : ((k == 9) ? 32'h55 : k);
            got_b = (off + k < bytes_q.size()) ? int'(bytes_q[off + k]) : -1;
            chk($sformatf("%s_byte%0d", tag, k), got_b, exp_b);
        end
    endtask

    task automatic wait_acks(input int n, input string tag);
        int k;
        k = 0;
        while (acks < n && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk({tag, "_ack_reached"}, (acks >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_busy_a();
        int k;
        k = 0;
        while (!busy_a && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("busy_a_rise", int'(busy_a), 1);
    endtask

    // Buffer models: data for address i is i+1, one cycle after rd_en.
    initial begin
        bus_a.rd_data = 8'h00;
        bus_b.rd_data = 8'h00;
        forever begin
            @(posedge clk);
            if (bus_a.rd_en) bus_a.rd_data <= 8'(bus_a.rd_addr) + 8'd1;
            if (bus_b.rd_en) bus_b.rd_data <= 8'(bus_b.rd_addr) + 8'd1;
        end
    end

    // Transmitter ready: always high, or high one cycle in three.
    initial begin
        bus_a.tx_ready = 1'b1;
        bus_b.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy_cnt++;
            bus_a.tx_ready = (ready_mode == 0) ? 1'b1 : ((rdy_cnt % 3) == 0);
        end
    end

    // Monitors sample on the falling edge, away from the active edge.
    initial begin
        clr();
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                prev_valid = 1'b0;
            end else begin
                if (prev_valid && !prev_ready &&
                    (!bus_a.tx_valid || bus_a.tx_data != prev_data)) stall_viol++;
                if (bus_a.tx_valid && bus_a.tx_ready) begin
                    bytes_q.push_back(bus_a.tx_data);
                    tcyc_q.push_back(cyc);
                end
                if (bus_a.rd_en) begin
                    reads++;
                    if (reads == 1) first_addr = int'(bus_a.rd_addr);
                    if (int'(bus_a.rd_addr) > max_addr) max_addr = int'(bus_a.rd_addr);
                end else if (bus_a.rd_addr != '0) begin
                    addr_viol++;
                end
                if (ack_a) acks++;
                if (acks == 1 && !busy_a) idle_gap++;
                prev_valid = bus_a.tx_valid;
                prev_ready = bus_a.tx_ready;
                prev_data  = bus_a.tx_data;

                if (bus_b.tx_valid && bus_b.tx_ready) begin
                    b_xfers++;
                    b_last = int'(bus_b.tx_data);
                end
                if (bus_b.rd_en) begin
                    b_reads++;
                    if (int'(bus_b.rd_addr) > b_max) b_max = int'(bus_b.rd_addr);
                end
                if (ack_b) b_acks++;
            end
        end
    end

    initial begin
        int k;
        reset_n = 1'b0;
        fr_a = 1'b0;
        fr_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", int'(bus_a.tx_valid), 0);
        chk("rst_rd_en", int'(bus_a.rd_en), 0);
        chk("rst_frame_ack", int'(ack_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_tx_data", int'(bus_a.tx_data), 0);
        chk("rst_rd_addr", int'(bus_a.rd_addr), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame, tx_ready tied high.
        clr();
        ready_mode = 0;
        fr_a = 1'b1;
        wait_busy_a();
        fr_a = 1'b0;
        wait_acks(1, "basic");
        repeat (5) @(posedge clk);
        #1;
        chk("basic_xfers", bytes_q.size(), 10);
        check_stream("basic", 0);
        chk("basic_acks", acks, 1);
        chk("basic_reads", reads, 8);
        chk("basic_max_addr", max_addr, 7);
        chk("basic_addr_idle0", addr_viol, 0);
        chk("basic_px_spacing", (tcyc_q.size() >= 9) ? (tcyc_q[8] - tcyc_q[1]) : -1, 21);
        chk("basic_busy_after", int'(busy_a), 0);

        // Back-pressure: ready one cycle in three.
        clr();
        ready_mode = 1;
        fr_a = 1'b1;
        wait_busy_a();
        fr_a = 1'b0;
        wait_acks(1, "bp");
        repeat (5) @(posedge clk);
        #1;
        chk("bp_xfers", bytes_q.size(), 10);
        check_stream("bp", 0);
        chk("bp_stable", stall_viol, 0);
        chk("bp_acks", acks, 1);
        ready_mode = 0;

        // frame_ready dropped after the third pixel.
        clr();
        fr_a = 1'b1;
        k = 0;
        while (bytes_q.size() < 4 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        fr_a = 1'b0;
        wait_acks(1, "drop");
        repeat (20) @(posedge clk);
        #1;
        chk("drop_xfers", bytes_q.size(), 10);
        check_stream("drop", 0);
        chk("drop_acks", acks, 1);
        chk("drop_idle", int'(busy_a), 0);

        // Reset during pixel 5, then a fresh frame.
        clr();
        fr_a = 1'b1;
        k = 0;
        while (reads < 5 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        reset_n = 1'b0;
        fr_a = 1'b0;
        #1;
        chk("mrst_busy", int'(busy_a), 0);
        chk("mrst_tx_valid", int'(bus_a.tx_valid), 0);
        chk("mrst_tx_data", int'(bus_a.tx_data), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mrst_no_ack", acks, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_idle", int'(busy_a), 0);
        clr();
        fr_a = 1'b1;
        wait_busy_a();
        fr_a = 1'b0;
        wait_acks(1, "mrst");
        repeat (5) @(posedge clk);
        #1;
        chk("mrst_xfers", bytes_q.size(), 10);
        check_stream("mrst", 0);
        chk("mrst_first_addr", first_addr, 0);
        chk("mrst_acks", acks, 1);

        // frame_ready held across two frames.
        clr();
        fr_a = 1'b1;
        wait_acks(2, "two");
        fr_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("two_xfers", bytes_q.size(), 20);
        check_stream("two_f1", 0);
        check_stream("two_f2", 10);
        chk("two_acks", acks, 2);
        chk("two_idle_gap", (idle_gap >= 1) ? 1 : 0, 1);

        // 5x3 instance: counter stops at 14 with no wrap.
        fr_b = 1'b1;
        k = 0;
        while (!busy_b && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        fr_b = 1'b0;
        k = 0;
        while (b_acks < 1 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("b_xfers", b_xfers, 17);
        chk("b_reads", b_reads, 15);
        chk("b_max_addr", b_max, 14);
        chk("b_last_byte", b_last, 32'h55);
        chk("b_acks", b_acks, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_tx_ctrl.md
FRAME_TX_CTRL -- requirements
Module: frame_tx_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 176, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 240, image height in pixels.
REQ-003 SHALL have parameter SOF_BYTE, default 8'hAA, start-of-frame marker.
REQ-004 SHALL have parameter EOF_BYTE, default 8'h55, end-of-frame marker.
REQ-005 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port frame_ready, input, 1, level, a completed edge frame is held in the buffer.
REQ-008 SHALL have port rd_en, output, 1, buffer read strobe.
REQ-009 SHALL have port rd_addr, output, AW=$clog2(IMG_W*IMG_H), buffer read address.
REQ-010 SHALL have port rd_data, input, 8, buffer data, valid exactly 1 cycle after rd_en.
REQ-011 SHALL have port tx_valid, output, 1, byte offered to the UART transmitter.
REQ-012 SHALL have port tx_data, output, 8, byte offered.
REQ-013 SHALL have port tx_ready, input, 1, transmitter accepts; a transfer occurs on tx_valid && tx_ready.
REQ-014 SHALL have port frame_ack, output, 1, one-cycle pulse when the frame is fully sent.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, SOF, RD, CAP, SEND, EOF, ACK.
REQ-017 IDLE -> SOF when frame_ready is 1; pixel counter cleared to 0.
REQ-018 SOF: tx_valid=1, tx_data=SOF_BYTE; on transfer -> RD.
REQ-019 RD: rd_en=1 for exactly one cycle, rd_addr=pixel counter; -> CAP.
REQ-020 CAP: register rd_data into tx_data; -> SEND.
REQ-021 SEND: tx_valid=1, tx_data held stable until transfer; on transfer: if counter == IMG_W*IMG_H-1 -> EOF, else counter+1 and -> RD.
REQ-022 EOF: tx_valid=1, tx_data=EOF_BYTE; on transfer -> ACK.
REQ-023 ACK: frame_ack=1 for one cycle; -> IDLE.
REQ-024 tx_valid SHALL never drop, and tx_data never change, while tx_valid=1 and tx_ready=0.
REQ-025 tx_ready arriving in the same cycle tx_valid rises SHALL complete the transfer in that cycle.
REQ-026 rd_addr SHALL be 0 outside RD; counter SHALL never exceed IMG_W*IMG_H-1 (no wrap).
REQ-027 frame_ready falling mid-frame SHALL be ignored; the frame completes.
REQ-028 frame_ready still high in ACK SHALL NOT start a frame until the cycle after return to IDLE.
REQ-029 Per-frame transfer count SHALL be exactly IMG_W*IMG_H+2 bytes; reads exactly IMG_W*IMG_H.
REQ-030 With tx_ready tied 1, pixel throughput SHALL be one byte per 3 cycles (RD, CAP, SEND).

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE, counter=0, tx_data=0, and rd_en, tx_valid, frame_ack, busy all 0.
REQ-032 Reset mid-frame SHALL abandon the frame without asserting frame_ack; the next frame restarts at SOF, address 0.

Structure
REQ-033 State enum and the SOF/EOF defaults SHALL live in a shared package (plotter_pkg).
REQ-034 Counter width AW SHALL be derived from IMG_W*IMG_H, not hard-coded.
REQ-035 No sub-module; single FSM plus counter.

Verification
REQ-036 tx_ready=1, IMG_W=4, IMG_H=2, mem[i]=i+1 -> bytes AA,01..08,55; one frame_ack; 10 transfers.
REQ-037 tx_ready toggling 1-of-3 cycles -> identical byte stream; tx_data stable while tx_valid && !tx_ready.
REQ-038 frame_ready dropped after 3rd pixel -> full frame still sent, frame_ack pulses once.
REQ-039 reset_n low during pixel 5, then frame_ready=1 -> no frame_ack before reset; new stream starts AA, rd_addr 0.
REQ-040 frame_ready held high across two frames -> two complete streams, at least one IDLE cycle between them.
REQ-041 Default parameters, tx_ready=1 -> 42242 transfers; last rd_addr 42239; never exceeds 42239.
